debug_sequencer: RTL and testbench

- Control FSM directly downstream of the debug port's request/opcode registers.
- Consumes the latched debug opcode and request level, and drives the port's address-load, address-increment and data-capture strobes.
- Arbitrates CPU halt/single-step and performs debug memory reads/writes with a ready handshake.
- Returns a one-cycle acknowledge to the port's request generator.

---
 rtl/debug_pkg.sv | 28 ++
 rtl/debug_mem_watchdog.sv | 27 ++
 rtl/debug_sequencer.sv | 175 +++++++++++++++++
 tb/tb_debug_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug port: opcodes, sequencer state encoding and
// output-register source selects.
package debug_pkg;

  localparam logic [2:0] DEBUG_OP_NOP       = 3'd0;
  localparam logic [2:0] DEBUG_OP_LOAD_ADDR = 3'd1;
  localparam logic [2:0] DEBUG_OP_MEM_WRITE = 3'd2;
  localparam logic [2:0] DEBUG_OP_MEM_READ  = 3'd3;
  localparam logic [2:0] DEBUG_OP_CAPTURE   = 3'd4;
  localparam logic [2:0] DEBUG_OP_STEP      = 3'd5;

  // Source selects for the port's output data register.
  localparam logic [1:0] DEBUG_DATAX_MEM    = 2'd0;
  localparam logic [1:0] DEBUG_DATAX_PC     = 2'd1;
  localparam logic [1:0] DEBUG_DATAX_REG    = 2'd2;
  localparam logic [1:0] DEBUG_DATAX_STATUS = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMem,
    StStepRun,
    StStepHalt,
    StDone,
    StRelease
  } debug_state_e;

endpackage

// File: rtl/debug_mem_watchdog.sv
// Counts MEM-state cycles without MEM_RDY and flags the cycle that reaches the
// timeout limit. Only instantiated when DEBUG_MEM_TIMEOUT_EN is defined.
module debug_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [TO_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose missing RDY would bring the count up to the limit.
  assign expired_o = cnt_en_i && (cnt_q == TO_WIDTH'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/debug_sequencer.sv
// Debug port control FSM: decodes latched opcodes, arbitrates halt/step and runs
// debug memory accesses. Optional MEM timeout guarded by DEBUG_MEM_TIMEOUT_EN.
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DEBUG_REQ,
  input  logic [2:0] DEBUG_OP,
  input  logic       DEBUG_STOP,
  output logic       DEBUG_ACK,
  output logic       DEBUG_ERR,
  output logic       DEBUG_BUSY,
  output logic       DEBUG_ADDR_LD,
  output logic       DEBUG_ADDR_INC,
  output logic       DEBUG_DOUT_LD,
  output logic       CPU_HALT_REQ,
  input  logic       CPU_HALTED,
  output logic       CPU_STEP,
  output logic       MEM_RD,
  output logic       MEM_WR,
  input  logic       MEM_RDY
);

  if (MEM_TIMEOUT >= (64'd1 << TO_WIDTH)) begin : g_bad_to_width
    $error("TO_WIDTH too narrow for MEM_TIMEOUT");
  end

  debug_state_e state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic         err_next_q, err_next_d;
  logic         inc_next_q, inc_next_d;
  logic         mem_rd_q, mem_rd_d;
  logic         mem_wr_q, mem_wr_d;
  logic         step_q, step_d;
  logic         addr_ld_q, addr_ld_d;
  logic         dout_ld_q, dout_ld_d;
  logic         ack_q, err_q, busy_q, addr_inc_q, halt_req_q;
  logic         mem_timeout;

`ifdef DEBUG_MEM_TIMEOUT_EN
  logic mem_enter;
  assign mem_enter = (state_q == StExec) && (state_d == StMem);

  debug_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_WIDTH   (TO_WIDTH)
  ) u_mem_watchdog (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clr_i    (mem_enter),
    .cnt_en_i ((state_q == StMem) && !MEM_RDY),
    .expired_o(mem_timeout)
  );
`else
  assign mem_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_next_d = err_next_q;
    inc_next_d = inc_next_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    step_d     = 1'b0;
    addr_ld_d  = 1'b0;
    dout_ld_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (DEBUG_REQ) begin
          op_d      = DEBUG_OP;
          state_d   = StExec;
          // Opcode-only strobes are registered ahead so they land in the EXEC cycle.
          addr_ld_d = (DEBUG_OP == DEBUG_OP_LOAD_ADDR);
          dout_ld_d = (DEBUG_OP == DEBUG_OP_CAPTURE);
        end
      end
      StExec: begin
        err_next_d = 1'b0;
        inc_next_d = 1'b0;
        state_d    = StDone;
        case (op_q)
          DEBUG_OP_NOP, DEBUG_OP_LOAD_ADDR, DEBUG_OP_CAPTURE: state_d = StDone;
          DEBUG_OP_MEM_WRITE, DEBUG_OP_MEM_READ: begin
            if (CPU_HALTED) begin
              state_d  = StMem;
              mem_wr_d = (op_q == DEBUG_OP_MEM_WRITE);
              mem_rd_d = (op_q == DEBUG_OP_MEM_READ);
            end else begin
              err_next_d = 1'b1;
            end
          end
          DEBUG_OP_STEP: begin
            if (CPU_HALTED) begin
              state_d = StStepRun;
              step_d  = 1'b1;
            end else begin
              err_next_d = 1'b1;
            end
          end
          default: err_next_d = 1'b1;
        endcase
      end
      StMem: begin
        if (MEM_RDY) begin
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          inc_next_d = 1'b1;
          state_d    = StDone;
        end else if (mem_timeout) begin
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          err_next_d = 1'b1;
          state_d    = StDone;
        end
      end
      StStepRun:  if (!CPU_HALTED) state_d = StStepHalt;
      StStepHalt: if (CPU_HALTED) state_d = StDone;
      StDone:     state_d = StRelease;
      StRelease:  if (!DEBUG_REQ) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      op_q       <= '0;
      err_next_q <= 1'b0;
      inc_next_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      step_q     <= 1'b0;
      addr_ld_q  <= 1'b0;
      dout_ld_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      addr_inc_q <= 1'b0;
      halt_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_next_q <= err_next_d;
      inc_next_q <= inc_next_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      step_q     <= step_d;
      addr_ld_q  <= addr_ld_d;
      dout_ld_q  <= dout_ld_d;
      ack_q      <= (state_d == StDone);
      addr_inc_q <= (state_d == StDone) && inc_next_d;
      if (state_d == StDone) err_q <= err_next_d;
      busy_q     <= (state_d != StIdle);
      halt_req_q <= DEBUG_STOP;
    end
  end

  assign DEBUG_ACK      = ack_q;
  assign DEBUG_ERR      = err_q;
  assign DEBUG_BUSY     = busy_q;
  assign DEBUG_ADDR_LD  = addr_ld_q;
  assign DEBUG_ADDR_INC = addr_inc_q;
  // Read data is captured in the RDY cycle itself, which cannot be registered ahead.
  assign DEBUG_DOUT_LD  = dout_ld_q || ((state_q == StMem) && mem_rd_q && MEM_RDY);
  assign CPU_HALT_REQ   = halt_req_q;
  assign CPU_STEP       = step_q;
  assign MEM_RD         = mem_rd_q;
  assign MEM_WR         = mem_wr_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: directed and random requests against a
// transaction-level model, with simple CPU and memory responders.
module tb_debug_sequencer;

`ifdef DEBUG_MEM_TIMEOUT_EN
  localparam int ToLimit = 4;
`else
  localparam int ToLimit = 1 << 30;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DEBUG_REQ = 1'b0;
  logic [2:0] DEBUG_OP = '0;
  logic       DEBUG_STOP = 1'b0;
  logic       DEBUG_ACK, DEBUG_ERR, DEBUG_BUSY, DEBUG_ADDR_LD, DEBUG_ADDR_INC, DEBUG_DOUT_LD;
  logic       CPU_HALT_REQ, CPU_STEP, MEM_RD, MEM_WR;
  logic       CPU_HALTED = 1'b0;
  logic       MEM_RDY = 1'b0;

  debug_sequencer #(
    .MEM_TIMEOUT(4),
    .TO_WIDTH   (8)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .DEBUG_REQ     (DEBUG_REQ),
    .DEBUG_OP      (DEBUG_OP),
    .DEBUG_STOP    (DEBUG_STOP),
    .DEBUG_ACK     (DEBUG_ACK),
    .DEBUG_ERR     (DEBUG_ERR),
    .DEBUG_BUSY    (DEBUG_BUSY),
    .DEBUG_ADDR_LD (DEBUG_ADDR_LD),
    .DEBUG_ADDR_INC(DEBUG_ADDR_INC),
    .DEBUG_DOUT_LD (DEBUG_DOUT_LD),
    .CPU_HALT_REQ  (CPU_HALT_REQ),
    .CPU_HALTED    (CPU_HALTED),
    .CPU_STEP      (CPU_STEP),
    .MEM_RD        (MEM_RD),
    .MEM_WR        (MEM_WR),
    .MEM_RDY       (MEM_RDY)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    int err;
    int inc;
    int ld;
    int dl;
    int rd;
    int wr;
    int st;
    int lat;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   abort    = 0;
  bit   mon_en   = 0;
  bit   halt_cmd = 0;
  int   mem_delay = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transaction-level expectation derived from opcode, CPU state and RDY delay.
  function automatic exp_t model(input int op, input bit halted, input int delay);
    exp_t e;
    e = '{default: 0};
    e.lat = 2;
    case (op)
      0: ;
      1: e.ld = 1;
      4: e.dl = 1;
      2, 3: begin
        if (!halted) begin
          e.err = 1;
        end else if (delay >= 0 && delay + 1 <= ToLimit) begin
          if (op == 2) e.wr = delay + 1;
          else e.rd = delay + 1;
          e.dl  = (op == 3) ? 1 : 0;
          e.inc = 1;
          e.lat = 2 + delay + 1;
        end else begin
          if (op == 2) e.wr = ToLimit;
          else e.rd = ToLimit;
          e.err = 1;
          e.lat = 2 + ToLimit;
        end
      end
      5: begin
        if (!halted) e.err = 1;
        else begin
          e.st  = 1;
          e.lat = -1;
        end
      end
      default: e.err = 1;
    endcase
    return e;
  endfunction

  // Memory responder: RDY in strobe cycle delay+1; delay<0 never answers.
  int mem_cyc = 0;
  always @(posedge CLK) begin
    #1;
    if (MEM_RD || MEM_WR) begin
      mem_cyc++;
      MEM_RDY = (mem_delay >= 0) && (mem_cyc == mem_delay + 1);
    end else begin
      mem_cyc = 0;
      MEM_RDY = 1'b0;
    end
  end

  // CPU model: a step pulse drops HALTED for two cycles, then it reasserts.
  int run_left = 0;
  always @(posedge CLK) begin
    #1;
    if (CPU_STEP) begin
      CPU_HALTED = 1'b0;
      run_left = 2;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) CPU_HALTED = 1'b1;
    end else begin
      CPU_HALTED = halt_cmd;
    end
  end

  logic stop_at_edge = 1'b0;
  always @(posedge CLK) stop_at_edge = DEBUG_STOP;

  // Monitor / scoreboard.
  bit   req_prev = 0;
  bit   post = 1;
  int   cyc = 0, extra = 0, err_model = 0;
  int   c_ld = 0, c_dl = 0, c_rd = 0, c_wr = 0, c_st = 0;
  exp_t e_pop;
  always @(negedge CLK) begin
    if (!mon_en) begin
      req_prev = DEBUG_REQ;
      post = 1;
      extra = 0;
      if (RESET) err_model = 0;
    end else begin
      if (DEBUG_REQ && !req_prev) begin
        chk("no_strobe_after_ack", extra, 0);
        c_ld = 0; c_dl = 0; c_rd = 0; c_wr = 0; c_st = 0;
        cyc = 0; post = 0; extra = 0;
      end else begin
        cyc++;
      end
      req_prev = DEBUG_REQ;
      if (post) begin
        extra += int'(DEBUG_ADDR_LD | DEBUG_DOUT_LD | MEM_RD | MEM_WR | CPU_STEP |
                      DEBUG_ACK | DEBUG_ADDR_INC);
      end else begin
        c_ld += int'(DEBUG_ADDR_LD);
        c_dl += int'(DEBUG_DOUT_LD);
        c_rd += int'(MEM_RD);
        c_wr += int'(MEM_WR);
        c_st += int'(CPU_STEP);
      end
      if (DEBUG_ACK && !post) begin
        if (q_exp.size() == 0) begin
          chk("ack_without_request", 1, 0);
        end else begin
          e_pop = q_exp.pop_front();
          chk("ack_err", int'(DEBUG_ERR), e_pop.err);
          chk("ack_addr_inc", int'(DEBUG_ADDR_INC), e_pop.inc);
          chk("addr_ld_pulses", c_ld, e_pop.ld);
          chk("dout_ld_pulses", c_dl, e_pop.dl);
          chk("mem_rd_cycles", c_rd, e_pop.rd);
          chk("mem_wr_cycles", c_wr, e_pop.wr);
          chk("cpu_step_pulses", c_st, e_pop.st);
          chk("busy_at_ack", int'(DEBUG_BUSY), 1);
          if (e_pop.lat >= 0) chk("ack_latency", cyc, e_pop.lat);
          err_model = e_pop.err;
        end
        post = 1;
      end else begin
        chk("err_hold", int'(DEBUG_ERR), err_model);
        if (!post) chk("addr_inc_only_with_ack", int'(DEBUG_ADDR_INC), 0);
      end
      chk("halt_req_follows_stop", int'(CPU_HALT_REQ), int'(stop_at_edge));
    end
  end

  task automatic do_op(input int op, input bit halted, input int delay, input bit stop,
                       input int hold);
    bit got;
    halt_cmd   = halted;
    DEBUG_STOP = stop;
    mem_delay  = delay;
    repeat (2) @(posedge CLK);
    #1;
    q_exp.push_back(model(op, halted, delay));
    DEBUG_OP  = 3'(op);
    DEBUG_REQ = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      if (DEBUG_ACK) got = 1;
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      abort = 1;
      return;
    end
    repeat (hold) @(posedge CLK);
    @(posedge CLK);
    #1;
    DEBUG_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("busy_idle_after_release", int'(DEBUG_BUSY), 0);
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ack", int'(DEBUG_ACK), 0);
    chk("reset_err", int'(DEBUG_ERR), 0);
    chk("reset_busy", int'(DEBUG_BUSY), 0);
    chk("reset_strobes", int'({DEBUG_ADDR_LD, DEBUG_ADDR_INC, DEBUG_DOUT_LD, CPU_HALT_REQ,
                                CPU_STEP, MEM_RD, MEM_WR}), 0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    mon_en = 1;

    do_op(1, 1, 0, 0, 3);
    if (!abort) do_op(2, 1, 3, 1, 0);
    if (!abort) do_op(3, 1, 0, 1, 1);
    if (!abort) do_op(2, 0, 0, 0, 0);
    if (!abort) do_op(0, 0, 0, 0, 2);
    if (!abort) do_op(5, 1, 0, 1, 0);
    if (!abort) do_op(7, 1, 0, 0, 0);
    if (!abort) do_op(4, 1, 0, 0, 1);
    if (!abort) do_op(6, 0, 0, 1, 0);
`ifdef DEBUG_MEM_TIMEOUT_EN
    if (!abort) do_op(3, 1, -1, 1, 0);
    if (!abort) do_op(2, 1, 3, 1, 0);
`endif
    for (int n = 0; n < 40 && !abort; n++) begin
      int d;
      d = int'($urandom_range(0, 5));
`ifdef DEBUG_MEM_TIMEOUT_EN
      if ($urandom_range(0, 5) == 0) d = -1;
`endif
      do_op(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, d,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset landing on the same edge as MEM_RDY: no ACK, strobe gone.
    if (!abort) begin
      mon_en     = 0;
      halt_cmd   = 1;
      mem_delay  = 1;
      repeat (2) @(posedge CLK);
      #1;
      DEBUG_OP  = 3'd3;
      DEBUG_REQ = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if (MEM_RD) got = 1;
      end
      chk("mid_mem_rd_seen", int'(got), 1);
      @(negedge CLK);
      RESET     = 1'b1;
      DEBUG_REQ = 1'b0;
      @(negedge CLK);
      chk("reset_mid_mem_rd", int'(MEM_RD), 0);
      chk("reset_mid_mem_wr", int'(MEM_WR), 0);
      chk("reset_mid_mem_ack", int'(DEBUG_ACK), 0);
      chk("reset_mid_mem_busy", int'(DEBUG_BUSY), 0);
      chk("reset_mid_mem_err", int'(DEBUG_ERR), 0);
      RESET = 1'b0;
      got = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        if (DEBUG_ACK || MEM_RD) got = 1;
      end
      chk("no_ack_after_reset", int'(got), 0);
      mon_en = 1;
      if (!abort) do_op(0, 1, 0, 0, 0);
    end

    chk("scoreboard_drained", q_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
